// File: rtl/decompression_engine.sv
// decompression_engine: 2-stage valid/ready decoder turning {mantissa, exponent} codes into 24-bit magnitudes.
// Define DECOMP_MIDPOINT_EN to fill the truncated low bits of legal codes with the midpoint pattern.
module decompression_engine #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [11:0]          mantissa_i,
    input  logic [3:0]           exponent_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [23:0]          num_o,
    output logic                 err_o,
    output logic                 err_sticky_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    input  logic                 err_clr_i
);
    logic                 s1_v_q, s1_ill_q, s2_v_q, s2_err_q, sticky_q, sticky_d;
    logic [11:0]          s1_m_q;
    logic [3:0]           s1_e_q;
    logic [23:0]          s2_num_q, num_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 s2_adv, in_fire, in_ill;

    assign s2_adv     = ~s2_v_q | out_ready_i;
    assign in_ready_o = reset & (~s1_v_q | s2_adv);
    assign in_fire    = in_valid_i & in_ready_o;
    assign in_ill     = (exponent_i > 4'd12) | ((exponent_i != 4'd0) & ~mantissa_i[11]);

    assign out_valid_o  = s2_v_q;
    assign num_o        = s2_num_q;
    assign err_o        = s2_err_q;
    assign err_sticky_o = sticky_q;
    assign err_cnt_o    = cnt_q;

    always_comb begin
        num_d = {12'h000, s1_m_q} << s1_e_q;
`ifdef DECOMP_MIDPOINT_EN
        num_d = (s1_e_q != 4'd0) ? (num_d | ((24'h1 << s1_e_q) >> 1)) : num_d;
`endif
        num_d = s1_ill_q ? 24'h0 : num_d;
    end

    // Clear wins over a same-cycle illegal accept; the counter sticks at all-ones.
    always_comb begin
        cnt_d    = err_clr_i ? '0 : cnt_q + ERR_CNT_W'(in_fire & in_ill & ~&cnt_q);
        sticky_d = ~err_clr_i & (sticky_q | (in_fire & in_ill));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v_q   <= 1'b0;
            s1_ill_q <= 1'b0;
            s1_m_q   <= '0;
            s1_e_q   <= '0;
            s2_v_q   <= 1'b0;
            s2_err_q <= 1'b0;
            s2_num_q <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (in_ready_o) begin
                s1_v_q <= in_valid_i;
                if (in_valid_i) begin
                    s1_m_q   <= mantissa_i;
                    s1_e_q   <= exponent_i;
                    s1_ill_q <= in_ill;
                end
            end
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_num_q <= num_d;
                    s2_err_q <= s1_ill_q;
                end
            end
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_decompression_engine.sv
// tb_decompression_engine: queue-based reference model checked every cycle, plus directed literal checks.
module tb_decompression_engine;
`ifdef DECOMP_MIDPOINT_EN
    localparam bit MID = 1'b1;
`else
    localparam bit MID = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
    logic [11:0] mantissa = '0;
    logic [3:0]  exponent = '0;
    logic        in_ready_o, out_valid_o, err_o, err_sticky_o;
    logic [23:0] num_o;
    logic [7:0]  err_cnt_o;
    logic        s_in_ready, s_out_valid, s_err, s_sticky;
    logic [23:0] s_num;
    logic [1:0]  s_cnt;

    int tests = 0, fails = 0;
    longint cyc = 0;

    decompression_engine u_dut (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .mantissa_i(mantissa), .exponent_i(exponent), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready), .num_o(num_o), .err_o(err_o), .err_sticky_o(err_sticky_o),
        .err_cnt_o(err_cnt_o), .err_clr_i(err_clr)
    );

    decompression_engine #(.ERR_CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .mantissa_i(mantissa), .exponent_i(exponent), .out_valid_o(s_out_valid),
        .out_ready_i(out_ready), .num_o(s_num), .err_o(s_err), .err_sticky_o(s_sticky),
        .err_cnt_o(s_cnt), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: value from the code rules, with plain arithmetic.
    function automatic void model(input logic [11:0] m, input logic [3:0] e,
                                  output logic [23:0] v, output bit ill);
        int ei;
        longint x;
        ei  = int'(e);
        ill = (ei > 12) || (ei != 0 && m < 12'h800);
        x   = longint'(m);
        repeat (ei) x = x * 2;
        if (MID && ei > 0) x = x + (longint'(1) << (ei - 1));
        v = ill ? 24'h0 : x[23:0];
    endfunction

    logic [23:0] q_num[$];
    bit          q_err[$];
    longint      q_acc[$];
    int          mcnt = 0, mcnt2 = 0;
    bit          msticky = 0, rst_seen = 0, mvalid, mready, mfire, mill;
    logic [23:0] mv;

    always @(negedge clk) begin
        if (!reset) begin
            if (rst_seen) begin
                chk("rst_out_valid", out_valid_o, 0);
                chk("rst_cnt", err_cnt_o, 0);
                chk("rst_sticky", err_sticky_o, 0);
                chk("rst_num", num_o, 0);
            end
            q_num.delete(); q_err.delete(); q_acc.delete();
            mcnt = 0; mcnt2 = 0; msticky = 0; rst_seen = 1;
        end else begin
            rst_seen = 0;
            mvalid = q_num.size() > 0 && cyc >= q_acc[0] + 2;
            mready = q_num.size() < 2 || out_ready;
            chk("in_ready", in_ready_o, mready);
            chk("out_valid", out_valid_o, mvalid);
            if (mvalid) begin
                chk("num", num_o, q_num[0]);
                chk("err", err_o, q_err[0]);
            end
            chk("err_cnt", err_cnt_o, mcnt);
            chk("err_cnt_w2", s_cnt, mcnt2);
            chk("err_sticky", err_sticky_o, msticky);
            mfire = in_valid && mready;
            mill  = 0;
            if (mvalid && out_ready) begin
                void'(q_num.pop_front()); void'(q_err.pop_front()); void'(q_acc.pop_front());
            end
            if (mfire) begin
                model(mantissa, exponent, mv, mill);
                q_num.push_back(mv); q_err.push_back(mill); q_acc.push_back(cyc);
            end
            if (err_clr) begin
                mcnt = 0; mcnt2 = 0; msticky = 0;
            end else if (mfire && mill) begin
                mcnt = (mcnt < 255) ? mcnt + 1 : 255;
                mcnt2 = (mcnt2 < 3) ? mcnt2 + 1 : 3;
                msticky = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] bm[8];
    logic [3:0]  be[8];
    logic [23:0] bn[8];
    bit          berr[8];

    // Back-to-back codes with the sink always ready; output i must appear 2 cycles after its accept.
    task automatic run_batch(input string name, input int n);
        out_ready = 1;
        in_valid = 1; mantissa = bm[0]; exponent = be[0];
        for (int i = 1; i <= n + 1; i++) begin
            tick();
            if (i < n) begin
                mantissa = bm[i]; exponent = be[i];
            end else in_valid = 0;
            @(negedge clk);
            if (i >= 2) begin
                chk({name, "_valid"}, out_valid_o, 1);
                chk({name, "_num"}, num_o, bn[i-2]);
                chk({name, "_err"}, err_o, berr[i-2]);
            end
        end
        tick();
    endtask

    initial begin
        bit fire;
        int idx;
        repeat (3) tick();
        reset = 1;
        tick();
        @(negedge clk);
        chk("reset_in_ready", in_ready_o, 1);
        chk("reset_out_valid", out_valid_o, 0);
        tick();

        bm[0] = 12'h123; be[0] = 4'd0;  bn[0] = 24'h000123;                  berr[0] = 0;
        bm[1] = 12'h800; be[1] = 4'd12; bn[1] = 24'h800000 | (24'(MID) << 11); berr[1] = 0;
        bm[2] = 12'hABC; be[2] = 4'd1;  bn[2] = 24'h001578 | 24'(MID);        berr[2] = 0;
        run_batch("legal", 3);

        bm[0] = 12'h7FF; be[0] = 4'd3;  bn[0] = 24'h0; berr[0] = 1;
        bm[1] = 12'h800; be[1] = 4'd13; bn[1] = 24'h0; berr[1] = 1;
        run_batch("illegal", 2);
        chk("cnt_two", err_cnt_o, 2);
        chk("sticky_set", err_sticky_o, 1);

        in_valid = 1; mantissa = 12'h7FF; exponent = 4'd3; err_clr = 1;
        tick();
        in_valid = 0; err_clr = 0;
        @(negedge clk);
        chk("clr_wins_cnt", err_cnt_o, 0);
        chk("clr_wins_sticky", err_sticky_o, 0);
        tick();

        for (int i = 0; i < 5; i++) begin
            bm[i] = 12'h001; be[i] = 4'(i + 1); bn[i] = 24'h0; berr[i] = 1;
        end
        run_batch("sat", 5);
        chk("sat_cnt_w8", err_cnt_o, 5);
        chk("sat_cnt_w2", s_cnt, 3);

        // Backpressure: sink stalled for 4 cycles while codes e=1..5 stream in.
        idx = 0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            out_ready = (c >= 4);
            in_valid = 1; mantissa = 12'hFFF; exponent = 4'(idx + 1);
            @(negedge clk);
            fire = in_ready_o;
            if (c == 3) begin
                chk("bp_in_ready_low", in_ready_o, 0);
                chk("bp_num_hold", num_o, 24'h001FFE | 24'(MID));
            end
            tick();
            if (fire) idx++;
        end
        chk("bp_all_accepted", idx, 5);
        in_valid = 0;
        repeat (4) tick();

        // Reset with two samples in flight.
        out_ready = 0;
        in_valid = 1; mantissa = 12'h900; exponent = 4'd2;
        tick();
        mantissa = 12'hA00; exponent = 4'd4;
        tick();
        in_valid = 0; reset = 0;
        tick();
        @(negedge clk);
        chk("midreset_out_valid", out_valid_o, 0);
        reset = 1; out_ready = 1;
        repeat (4) tick();

        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            mantissa  = 12'($urandom);
            if ($urandom % 4 != 0) mantissa[11] = 1'b1;
            exponent  = 4'($urandom % 15);
            out_ready = ($urandom % 4) != 0;
            err_clr   = ($urandom % 50) == 0;
            reset     = ($urandom % 500) != 0;
            tick();
        end
        reset = 1; in_valid = 0; err_clr = 0; out_ready = 1;
        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decompression_engine.md
Name: decompression_engine

Overview:
- Downstream consumer of the compression engine's 16-bit code stream ({mantissa[11:0], exponent[3:0]}).
- Reconstructs the 24-bit magnitude through a 2-stage valid/ready pipeline with full backpressure.
- Flags non-canonical or illegal codes and counts them.
- Sits between the compressed-sample link and the 24-bit sample sink.

Parameters:
- ERR_CNT_W, 8, width of the saturating illegal-code counter.

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- in_valid_i  input  1  code valid
- in_ready_o  output  1  block can accept a code this cycle
- mantissa_i  input  12  compressed mantissa
- exponent_i  input  4  compressed exponent
- out_valid_o  output  1  reconstructed sample valid
- out_ready_i  input  1  sink accepts sample
- num_o  output  24  reconstructed magnitude
- err_o  output  1  per-sample flag, qualified by out_valid_o: code was illegal
- err_sticky_o  output  1  set by any accepted illegal code; cleared by err_clr_i
- err_cnt_o  output  ERR_CNT_W  saturating count of accepted illegal codes
- err_clr_i  input  1  clears err_sticky_o and err_cnt_o

Behaviour:
- Code format:
  - e = 0: value = {12'h000, m}.
  - e in 1..12: value = m << e (24 bits); canonical requires m[11] = 1.
- Illegal code:
  - e > 12, or e in 1..12 with m[11] = 0.
  - Illegal codes still produce a sample: num_o = 24'h0, err_o = 1.
- Handshake:
  - Transfer on in_valid_i & in_ready_o, and on out_valid_o & out_ready_i.
  - Stage S1 registers the code and computes the illegal flag.
  - Stage S2 registers the shifted result; S2 drives the outputs.
  - in_ready_o = ~S1.v | (~S2.v | out_ready_i). Combinational from out_ready_i; no combinational path from in_valid_i.
  - S1 moves into S2 when S2 is empty or being drained.
  - Full throughput: 1 sample/cycle when out_ready_i is held high.
- Latency: accepted code appears on num_o exactly 2 cycles later with no stall. Each stall cycle adds 1 cycle.
- Output stability: while out_valid_o = 1 and out_ready_i = 0, num_o and err_o hold stable and the pipe holds. No drops, no duplicates.
- Reset values:
  - in_ready_o: 1 after the first clocked reset cycle; 0 during reset.
  - out_valid_o 0, num_o 0, err_o 0, err_sticky_o 0, err_cnt_o 0, all stage valids 0.
- Reset mid-operation discards in-flight samples; no output transfer occurs in the reset cycle.
- Error counter:
  - Increments when an illegal code is accepted at the input handshake.
  - Saturates at all-ones.
  - err_clr_i wins over a same-cycle increment: result is 0, sticky 0.
- Combinational values must not depend on X when in_valid_i = 0.

Optional Feature:
- Macro DECOMP_MIDPOINT_EN.
- Defined, for legal e >= 1: the bits truncated by the compressor are filled with the midpoint pattern, bit (e-1) = 1 and lower bits 0. Value = (m << e) | (1 << (e-1)).
- Not defined: truncated bits are 0.
- e = 0 and illegal codes are unaffected in both cases.

Test Plan:
- Reset, then m = 12'h123, e = 0 -> num_o = 24'h000123 two cycles after accept; err_o = 0.
- m = 12'h800, e = 12 -> 24'h800000; m = 12'hABC, e = 1 -> 24'h001578 (midpoint build: 24'h001579). Back-to-back with out_ready_i = 1 -> one output per cycle.
- Illegal codes m = 12'h7FF, e = 3 and m = 12'h800, e = 13 -> num_o = 0 with err_o = 1. err_cnt_o = 2, err_sticky_o = 1. Then err_clr_i pulse concurrent with a third illegal accept -> cnt 0, sticky 0.
- Backpressure:
  - Stream codes e = 1..5, m = 12'hFFF.
  - Hold out_ready_i = 0 for 4 cycles -> in_ready_o drops after S1 and S2 fill; num_o stable.
  - Release -> all 5 samples emerge in order, none lost or duplicated.
- Assert reset (0) with 2 samples in flight -> out_valid_o = 0 the next cycle; after release no stale sample appears.
- Saturation with ERR_CNT_W = 2: 5 illegal codes -> err_cnt_o = 3.
